spike_event_encoder: RTL and testbench
======================================

SPIKE_EVENT_ENCODER -- requirements
Module: spike_event_encoder

Interface
REQ-001 SHALL have parameter THRESH, default 8'sd19, spike threshold (signed; sample strictly greater fires).
REQ-002 SHALL have parameter REARM, default -8'sd16, re-arm level (signed; sample less than or equal re-arms).
REQ-003 SHALL have parameter ISI_W, default 12, inter-spike-interval width in bits.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, ISI FIFO entries (power of two, at least 2).
REQ-005 SHALL have parameter WIN_LOG2, default 8, rate window of 2^WIN_LOG2 valid samples.
REQ-006 SHALL have port clk, input, 1, clock; rising edge only.
REQ-007 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-008 SHALL have port v_valid, input, 1, sample strobe; one membrane sample per high cycle.
REQ-009 SHALL have port v_in, input, 8, signed membrane voltage sample (integer part of the neuron state).
REQ-010 SHALL have port spike, output, 1, one-cycle spike pulse.
REQ-011 SHALL have port isi_valid, output, 1, ISI FIFO non-empty.
REQ-012 SHALL have port isi_data, output, ISI_W, FIFO head, valid when isi_valid is high.
REQ-013 SHALL have port isi_ready, input, 1, consumer pop; a pop occurs when isi_valid and isi_ready are both high.
REQ-014 SHALL have port rate_count, output, 8, spikes in the last completed window.
REQ-015 SHALL have port rate_valid, output, 1, one-cycle pulse when rate_count updates.
REQ-016 SHALL have port ovf, output, 1, sticky flag: an ISI was dropped because the FIFO was full.

Function
REQ-017 SHALL implement FSM states NOPREV (no spike yet), ARMED and REFRACT, and SHALL leave NOPREV only on its first spike.
- "Qualifying sample": a clock edge with v_valid=1 and v_in > THRESH.
REQ-018 SHALL, in NOPREV or ARMED on a qualifying sample, raise spike for exactly the following cycle and go to REFRACT.
REQ-019 SHALL, in REFRACT, ignore samples above THRESH and return to ARMED on an edge with v_valid=1 and v_in <= REARM.
REQ-020 SHALL ignore v_in whenever v_valid=0, and SHALL NOT advance the FSM, the ISI counter or the window counter on such edges.
REQ-021 SHALL hold an ISI counter that clears to 0 on a spike edge and increments on every other valid sample, saturating at 2^ISI_W-2.
REQ-022 SHALL, on a spike edge from ARMED, push ISI = counter+1 (the sample-index difference), giving a maximum value of 2^ISI_W-1.
REQ-023 SHALL NOT push any ISI entry for the spike taken from NOPREV.
REQ-024 SHALL write the pushed entry on the spike edge, so isi_valid is high in the same cycle as spike when the FIFO was empty.
REQ-025 SHALL present the FIFO in first-in first-out order, and SHALL hold isi_data stable while isi_valid=1 and isi_ready=0.
REQ-026 SHALL, on a push while full with no simultaneous pop, drop the new entry, keep the stored entries and set ovf.
REQ-027 SHALL accept a push while full when a pop occurs on the same edge, leaving the count unchanged and ovf unchanged.
REQ-028 SHALL ignore isi_ready while the FIFO is empty.
REQ-029 SHALL give isi_data no defined value while empty; the bench SHALL NOT check it.

Reset
REQ-030 SHALL, on an edge with rst_n=0, set the FSM to NOPREV and clear the ISI counter, the FIFO pointers and count, the window counters and ovf.
REQ-031 SHALL drive these output values after reset: spike=0, isi_valid=0, rate_count=0, rate_valid=0, ovf=0.
REQ-032 SHALL give reset priority over all other inputs, discarding buffered ISIs and any partial window, including mid-operation.

Configuration
REQ-033 SHALL, with macro SPIKE_RATE_EN defined, count valid samples modulo 2^WIN_LOG2 and spikes per window.
REQ-034 SHALL, with SPIKE_RATE_EN defined, do the following on the edge of the last valid sample of a window:
- load rate_count with the window's spike total, including a spike on that same sample, saturating at 255;
- pulse rate_valid for the following cycle;
- restart both counters.
REQ-035 SHALL, without SPIKE_RATE_EN, omit the rate logic and tie rate_count=0 and rate_valid=0; all other behaviour is unchanged.

Verification
REQ-036 SHALL cover: reset, then v_valid=1 with v_in=20 at sample 0 -> spike pulse after that edge, isi_valid stays 0 (NOPREV), FSM in REFRACT.
REQ-037 SHALL cover: samples at -20 between peaks and peaks of 25 at sample indices 3 and 10 -> two spike pulses, one ISI entry of 7.
REQ-038 SHALL cover: v_in held at 30 for 5 samples with no dip to REARM or below -> exactly one spike pulse.
REQ-039 SHALL cover: isi_ready=0 and six ISI-producing spikes -> 4 entries held, ovf=1; then isi_ready=1 -> first 4 ISIs popped in order, isi_valid then 0.
REQ-040 SHALL cover: FIFO full, push and pop on the same edge -> count stays 4, newest ISI at the tail, ovf unchanged.
REQ-041 SHALL cover: SPIKE_RATE_EN defined, WIN_LOG2=4, 3 spikes in 16 valid samples with v_valid toggling -> rate_valid pulse with rate_count=3; then rst_n=0 mid-window -> rate_count=0.

Source files
------------

// File: rtl/spike_event_encoder_if.sv
// Bundled sample / spike / ISI-stream / rate signals for spike_event_encoder.
// The encoder takes the slave side and the stimulus or consumer takes the master side.
interface spike_event_encoder_if #(
  parameter int ISI_W = 12
);
  logic                    v_valid;
  logic signed [7:0]       v_in;
  logic                    spike;
  logic                    isi_valid;
  logic        [ISI_W-1:0] isi_data;
  logic                    isi_ready;
  logic        [7:0]       rate_count;
  logic                    rate_valid;
  logic                    ovf;

  modport slave (
    input  v_valid, v_in, isi_ready,
    output spike, isi_valid, isi_data, rate_count, rate_valid, ovf
  );

  modport master (
    output v_valid, v_in, isi_ready,
    input  spike, isi_valid, isi_data, rate_count, rate_valid, ovf
  );
endinterface

// File: rtl/spike_event_encoder.sv
// Threshold spike detector with refractory re-arm, inter-spike-interval FIFO and
// optional windowed spike-rate counter (enabled by defining SPIKE_RATE_EN).
module spike_event_encoder #(
  parameter logic signed [7:0] THRESH     = 8'sd19,
  parameter logic signed [7:0] REARM      = -8'sd16,
  parameter int                ISI_W      = 12,
  parameter int                FIFO_DEPTH = 4,
  parameter int                WIN_LOG2   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spike_event_encoder_if.slave  bus
);

  localparam logic [1:0] S_NOPREV  = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_REFRACT = 2'd2;

  localparam int               AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [ISI_W-1:0] CNT_MAX  = {{(ISI_W-1){1'b1}}, 1'b0};

  logic [1:0]       r_state;
  logic             r_spike;
  logic [ISI_W-1:0] r_isi_cnt;
  logic [ISI_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_ovf;

  logic w_qual, w_fire, w_push, w_pop, w_full, w_wr;

  assign w_qual = bus.v_valid && (bus.v_in > THRESH);
  assign w_fire = w_qual && (r_state != S_REFRACT);
  // The very first spike has no predecessor, so it produces no interval.
  assign w_push = w_fire && (r_state == S_ARMED);
  assign w_pop  = (r_count != '0) && bus.isi_ready;
  assign w_full = (r_count == FULL_CNT);
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_NOPREV;
    end else if (bus.v_valid) begin
      case (r_state)
        S_NOPREV, S_ARMED: if (w_qual) r_state <= S_REFRACT;
        S_REFRACT:         if (bus.v_in <= REARM) r_state <= S_ARMED;
        default:           r_state <= S_NOPREV;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_spike   <= 1'b0;
      r_isi_cnt <= '0;
    end else begin
      r_spike <= w_fire;
      if (w_fire)
        r_isi_cnt <= '0;
      else if (bus.v_valid && r_isi_cnt != CNT_MAX)
        r_isi_cnt <= r_isi_cnt + 1'b1;
    end
  end

  // Stored value is the sample-index distance, hence counter + 1.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_isi_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign bus.spike     = r_spike;
  assign bus.isi_valid = (r_count != '0);
  assign bus.isi_data  = r_mem[r_rd_ptr];
  assign bus.ovf       = r_ovf;

`ifdef SPIKE_RATE_EN
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [7:0]          r_spk_cnt;
  logic [7:0]          r_rate_count;
  logic                r_rate_valid;
  logic [7:0]          w_spk_next;

  // Saturating count that already includes a spike on the current sample.
  assign w_spk_next = (w_fire && r_spk_cnt != 8'hFF) ? r_spk_cnt + 8'd1 : r_spk_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_win_cnt    <= '0;
      r_spk_cnt    <= '0;
      r_rate_count <= '0;
      r_rate_valid <= 1'b0;
    end else begin
      r_rate_valid <= 1'b0;
      if (bus.v_valid) begin
        r_win_cnt <= r_win_cnt + 1'b1;
        if (&r_win_cnt) begin
          r_rate_count <= w_spk_next;
          r_rate_valid <= 1'b1;
          r_spk_cnt    <= '0;
        end else begin
          r_spk_cnt <= w_spk_next;
        end
      end
    end
  end

  assign bus.rate_count = r_rate_count;
  assign bus.rate_valid = r_rate_valid;
`else
  assign bus.rate_count = 8'd0;
  assign bus.rate_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder: detection, refractory, ISI FIFO order,
// overflow, simultaneous push/pop and the rate window (when SPIKE_RATE_EN is set).
module tb_spike_event_encoder;
  logic clk;
  logic rst_n;
  int   n_chk, n_pass;
  int   n_spk, n_rv;

  spike_event_encoder_if #(.ISI_W(12)) bus ();

  spike_event_encoder #(
    .THRESH(8'sd19), .REARM(-8'sd16), .ISI_W(12), .FIFO_DEPTH(4), .WIN_LOG2(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Inputs change at a falling edge; outputs are read at the next falling edge.
  task automatic step(input logic vv, input int vin, input logic rdy);
    bus.v_valid   = vv;
    bus.v_in      = 8'(vin);
    bus.isi_ready = rdy;
    @(negedge clk);
    if (bus.spike)      n_spk++;
    if (bus.rate_valid) n_rv++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    rst_n = 1'b1;
    n_spk = 0;
    n_rv  = 0;
  endtask

  // One initial spike, then spikes separated by 1..n re-arm samples: ISIs 2..n+1.
  task automatic spike_train(input int n);
    step(1, 25, 0);
    for (int g = 1; g <= n; g++) begin
      repeat (g) step(1, -20, 0);
      step(1, 25, 0);
      if (g == 4) begin
        chk("full_no_ovf_yet", int'(bus.ovf), 0);
        chk("full_isi_valid", int'(bus.isi_valid), 1);
      end
      if (g == 5) chk("ovf_set_on_drop", int'(bus.ovf), 1);
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    bus.v_valid = 1'b0; bus.v_in = '0; bus.isi_ready = 1'b0;
    @(negedge clk);

    do_reset();
    chk("rst_spike", int'(bus.spike), 0);
    chk("rst_isi_valid", int'(bus.isi_valid), 0);
    chk("rst_rate_count", int'(bus.rate_count), 0);
    chk("rst_rate_valid", int'(bus.rate_valid), 0);
    chk("rst_ovf", int'(bus.ovf), 0);

    // First spike from NOPREV, then refractory ignores further peaks
    step(1, 20, 0);
    chk("first_spike", int'(bus.spike), 1);
    chk("first_no_isi", int'(bus.isi_valid), 0);
    step(1, 25, 0);
    chk("refract_ignores", int'(bus.spike), 0);
    step(1, 19, 0);
    chk("thresh_not_strict", n_spk, 1);

    // Peaks at sample 3 and 10, invalid high sample in between is ignored
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      step(1, (i == 3 || i == 10) ? 25 : -20, 0);
      if (i == 5) step(0, 100, 0);
    end
    chk("isi_spike_same_cycle", int'(bus.spike), 1);
    chk("isi_valid_with_spike", int'(bus.isi_valid), 1);
    chk("isi_value_7", int'(bus.isi_data), 7);
    chk("two_spikes", n_spk, 2);
    step(0, 0, 1);
    chk("pop_to_empty", int'(bus.isi_valid), 0);

    // Held above threshold without re-arm
    do_reset();
    repeat (5) step(1, 30, 0);
    chk("held_one_spike", n_spk, 1);
    chk("held_no_isi", int'(bus.isi_valid), 0);

    // Overflow: six ISIs into four entries
    do_reset();
    spike_train(6);
    chk("ovf_spikes", n_spk, 7);
    step(0, 0, 0);
    chk("hold_head", int'(bus.isi_data), 2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_%0d", k), int'(bus.isi_data), k + 2);
      step(0, 0, 1);
    end
    chk("drained_empty", int'(bus.isi_valid), 0);
    step(0, 0, 1);
    chk("empty_ready_ignored", int'(bus.isi_valid), 0);
    chk("ovf_sticky", int'(bus.ovf), 1);

    // Full FIFO with simultaneous push and pop
    do_reset();
    spike_train(4);
    repeat (9) step(1, -20, 0);
    step(1, 25, 1);
    chk("pp_ovf_unchanged", int'(bus.ovf), 0);
    begin
      int exp_q [4] = '{3, 4, 5, 10};
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("pp_valid_%0d", k), int'(bus.isi_valid), 1);
        chk($sformatf("pp_data_%0d", k), int'(bus.isi_data), exp_q[k]);
        step(0, 0, 1);
      end
    end
    chk("pp_empty", int'(bus.isi_valid), 0);

`ifdef SPIKE_RATE_EN
    // 16 valid samples with v_valid toggling, spikes at 2, 7 and the last sample
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, (i == 2 || i == 7 || i == 15) ? 25 : -20, 0);
      if (i == 15) begin
        chk("rate_valid_pulse", int'(bus.rate_valid), 1);
        chk("rate_count_3", int'(bus.rate_count), 3);
      end else begin
        step(0, 100, 0);
      end
    end
    chk("rate_one_pulse", n_rv, 1);
    step(0, 0, 0);
    chk("rate_valid_drop", int'(bus.rate_valid), 0);
    chk("rate_count_hold", int'(bus.rate_count), 3);
    step(1, -20, 0);
    step(1, 25, 0);
    step(1, -20, 0);
    rst_n = 1'b0;
    step(1, 25, 0);
    rst_n = 1'b1;
    chk("rate_rst_count", int'(bus.rate_count), 0);
    chk("rate_rst_valid", int'(bus.rate_valid), 0);
    n_rv = 0;
    for (int i = 0; i < 15; i++) step(1, -20, 0);
    chk("rate_partial_discarded", n_rv, 0);
    step(1, -20, 0);
    chk("rate_fresh_window", int'(bus.rate_valid), 1);
    chk("rate_fresh_zero", int'(bus.rate_count), 0);
`else
    do_reset();
    for (int i = 0; i < 20; i++) step(1, (i % 4 == 0) ? 25 : -20, 0);
    chk("norate_no_pulse", n_rv, 0);
    chk("norate_count_zero", int'(bus.rate_count), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
